// File: rtl/przesuniecie_sekw.sv
// Multi-cycle arithmetic shifter: up to STEP bit positions per clock.
// Build option: PRZESUNIECIE_SAT_EN saturates left-shift overflow results.
module przesuniecie_sekw #(
    parameter int BITS = 32,
    parameter int STEP = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_mode,
    input  logic [BITS-1:0] i_arg_A,
    input  logic [BITS-1:0] i_arg_B,
    output logic            o_busy,
    output logic            o_done,
    output logic [BITS-1:0] o_result,
    output logic            o_error,
    output logic            o_overflow
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q;
    logic [BITS-1:0] work_q;
    logic [BITS-1:0] rem_q;
    logic            mode_q;
    logic            sign_q;
    logic            err_q;
    logic            ovf_q;

    logic [BITS-1:0] step_d;
    logic [BITS-1:0] work_d;
    logic [BITS-1:0] rem_d;
    logic [BITS-1:0] res_d;
    logic            ovf_d;
    logic            bad_b;

    assign bad_b = i_arg_B[BITS-1] || (i_arg_B >= BITS'(BITS));

    // One shift step; overflow if any bit leaving or landing in the MSB differs from the original sign
    always_comb begin
        step_d = (rem_q > BITS'(STEP)) ? BITS'(STEP) : rem_q;
        rem_d  = rem_q - step_d;
        if (mode_q) begin
            work_d = $signed(work_q) >>> step_d;
        end else begin
            work_d = work_q << step_d;
        end
        ovf_d = ovf_q;
        for (int i = 0; i < BITS; i++) begin
            if (!mode_q && (BITS'(i) <= step_d) && (work_q[BITS-1-i] != sign_q)) begin
                ovf_d = 1'b1;
            end
        end
        res_d = work_d;
`ifdef PRZESUNIECIE_SAT_EN
        if (!mode_q && ovf_d) begin
            res_d = sign_q ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
        end
`endif
    end

    // Control FSM with registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            work_q     <= '0;
            rem_q      <= '0;
            mode_q     <= 1'b0;
            sign_q     <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_result   <= '0;
            o_error    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        work_q     <= i_arg_A;
                        rem_q      <= i_arg_B;
                        mode_q     <= i_mode;
                        sign_q     <= i_arg_A[BITS-1];
                        err_q      <= bad_b;
                        ovf_q      <= 1'b0;
                        o_error    <= 1'b0;
                        o_overflow <= 1'b0;
                        o_busy     <= 1'b1;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (err_q) begin
                        rem_q      <= '0;
                        o_result   <= '0;
                        o_error    <= 1'b1;
                        o_overflow <= 1'b0;
                        o_busy     <= 1'b0;
                        o_done     <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        work_q <= work_d;
                        rem_q  <= rem_d;
                        ovf_q  <= ovf_d;
                        if (rem_d == '0) begin
                            o_result   <= res_d;
                            o_overflow <= ovf_d;
                            o_busy     <= 1'b0;
                            o_done     <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                end
                DONE: begin
                    o_done  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_przesuniecie_sekw.sv
// Directed testbench for przesuniecie_sekw (BITS=32, STEP=4).
// Expected values are hand-computed per scenario.
module tb_przesuniecie_sekw;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] res;
    logic        err;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;

    logic [41:0] got;
    logic [41:0] want;
    int          bc;

    przesuniecie_sekw #(.BITS(32), .STEP(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_mode     (mode),
        .i_arg_A    (a),
        .i_arg_B    (b),
        .o_busy     (busy),
        .o_done     (done),
        .o_result   (res),
        .o_error    (err),
        .o_overflow (ovf)
    );

    always #5 clk = ~clk;

`ifdef PRZESUNIECIE_SAT_EN
    localparam logic [31:0] OVF_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] OVF_NEG = 32'h8000_0000;
    localparam logic [31:0] OVF_ONE = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] OVF_POS = 32'h8000_0000;
    localparam logic [31:0] OVF_NEG = 32'h0000_0000;
    localparam logic [31:0] OVF_ONE = 32'h8000_0000;
`endif

    // Issue one request; returns {result, error, overflow, cycles-to-done} and busy count
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic tm,
                          output logic [41:0] g, output int busy_cnt);
        int cyc;
        @(negedge clk);
        a = ta; b = tb; mode = tm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~ta; b = tb + 32'd5; mode = ~tm;
        cyc = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (busy) busy_cnt++;
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout a=%h b=%h: o_done never seen", ta, tb);
        end
        g = {res, err, ovf, 8'(cyc)};
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, res, err, ovf} !== 36'd0) begin
            n_bad++;
            $display("FAIL reset_state got %h want 0", {busy, done, res, err, ovf});
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_left();
        run_op(32'd5, 32'd3, 1'b0, got, bc);
        want = {32'd40, 1'b0, 1'b0, 8'd1};
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL left_5x3 got %h want %h", got, want); end
        run_op(32'h1234, 32'd0, 1'b0, got, bc);
        want = {32'h1234, 1'b0, 1'b0, 8'd1};
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL left_zero got %h want %h", got, want); end
        run_op(32'd3, 32'd7, 1'b0, got, bc);
        want = {32'd384, 1'b0, 1'b0, 8'd2};
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL left_3x7 got %h want %h", got, want); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({res, done, busy} !== {32'd384, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL hold got %h want %h", {res, done, busy}, {32'd384, 2'b00});
        end
    endtask

    task automatic test_right();
        run_op(32'hFFFF_FFF8, 32'd2, 1'b1, got, bc);
        want = {32'hFFFF_FFFE, 1'b0, 1'b0, 8'd1};
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL right_m8 got %h want %h", got, want); end
        run_op(32'hFFFF_FFFF, 32'd31, 1'b1, got, bc);
        want = {32'hFFFF_FFFF, 1'b0, 1'b0, 8'd8};
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL right_m1 got %h want %h", got, want); end
        run_op(32'h8000_0000, 32'd31, 1'b1, got, bc);
        want = {32'hFFFF_FFFF, 1'b0, 1'b0, 8'd8};
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL right_min got %h want %h", got, want); end
        run_op(32'h1234_5678, 32'd13, 1'b1, got, bc);
        want = {32'h0000_91A2, 1'b0, 1'b0, 8'd4};
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL right_13 got %h want %h", got, want); end
        n_cmp++;
        if (bc !== 4) begin n_bad++; $display("FAIL busy_13 got %0d want 4", bc); end
    endtask

    task automatic test_overflow();
        run_op(32'h4000_0000, 32'd1, 1'b0, got, bc);
        want = {OVF_POS, 1'b0, 1'b1, 8'd1};
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL ovf_pos got %h want %h", got, want); end
        run_op(32'hFFFF_FFFF, 32'd31, 1'b0, got, bc);
        want = {32'h8000_0000, 1'b0, 1'b0, 8'd8};
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL left_m1_31 got %h want %h", got, want); end
        run_op(32'hC000_0000, 32'd2, 1'b0, got, bc);
        want = {OVF_NEG, 1'b0, 1'b1, 8'd1};
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL ovf_neg got %h want %h", got, want); end
        run_op(32'd1, 32'd31, 1'b0, got, bc);
        want = {OVF_ONE, 1'b0, 1'b1, 8'd8};
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL ovf_1x31 got %h want %h", got, want); end
        run_op(32'd1, 32'd30, 1'b0, got, bc);
        want = {32'h4000_0000, 1'b0, 1'b0, 8'd8};
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL left_1x30 got %h want %h", got, want); end
        run_op(32'hFFFF_FFFD, 32'd4, 1'b0, got, bc);
        want = {32'hFFFF_FFD0, 1'b0, 1'b0, 8'd1};
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL left_m3 got %h want %h", got, want); end
    endtask

    task automatic test_error();
        run_op(32'h4000_0000, 32'd1, 1'b0, got, bc);
        run_op(32'd9, 32'd32, 1'b0, got, bc);
        want = {32'd0, 1'b1, 1'b0, 8'd1};
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL err_32 got %h want %h", got, want); end
        run_op(32'd9, 32'd34, 1'b1, got, bc);
        want = {32'd0, 1'b1, 1'b0, 8'd1};
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL err_34 got %h want %h", got, want); end
        run_op(32'd9, 32'hFFFF_FFFF, 1'b0, got, bc);
        want = {32'd0, 1'b1, 1'b0, 8'd1};
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL err_m1 got %h want %h", got, want); end
        run_op(32'd7, 32'd1, 1'b0, got, bc);
        want = {32'd14, 1'b0, 1'b0, 8'd1};
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL err_clear got %h want %h", got, want); end
    endtask

    task automatic test_ignored_start();
        int cyc;
        int pulses;
        int busy_n;
        @(negedge clk);
        a = 32'd1; b = 32'd20; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        cyc = 0; pulses = 0; busy_n = busy ? 1 : 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (busy) busy_n++;
        end
        start = 1'b0;
        if (done) pulses++;
        n_cmp++;
        if ({res, 8'(cyc), 8'(busy_n)} !== {32'h0010_0000, 8'd5, 8'd5}) begin
            n_bad++;
            $display("FAIL ignored_start got %h want %h",
                     {res, 8'(cyc), 8'(busy_n)}, {32'h0010_0000, 8'd5, 8'd5});
        end
        repeat (8) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        n_cmp++;
        if (pulses !== 1) begin n_bad++; $display("FAIL single_done got %0d want 1", pulses); end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        a = 32'd1; b = 32'd24; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, res, err, ovf} !== 36'd0) begin
            n_bad++;
            $display("FAIL reset_mid got %h want 0", {busy, done, res, err, ovf});
        end
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL no_done_after_rst got %0d want 0", seen); end
        run_op(32'd3, 32'd1, 1'b0, got, bc);
        want = {32'd6, 1'b0, 1'b0, 8'd1};
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL after_rst got %h want %h", got, want); end
    endtask

    initial begin
        test_reset();
        test_left();
        test_right();
        test_overflow();
        test_error();
        test_ignored_start();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/przesuniecie_sekw.md
# przesuniecie_sekw

Sequential, parametrised arithmetic shifter for the synchronous arithmetic unit. It accepts a signed operand and a signed shift amount on a start strobe. It shifts left or right by up to STEP bit positions per clock, then reports the result with error and overflow flags. It replaces the single-cycle combinational shifter where wide operands or long shifts would break timing.

## Interface
- BITS, 32, operand, shift-amount and result width (≥ 4)
- STEP, 4, maximum bit positions shifted per clock (1 ≤ STEP ≤ BITS)

- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  request; sampled only in IDLE
- i_mode  in  1  0 = arithmetic left (<<<), 1 = arithmetic right (>>>)
- i_arg_A  in  BITS  signed operand
- i_arg_B  in  BITS  signed shift amount
- o_busy  out  1  high in BUSY
- o_done  out  1  one-cycle completion pulse
- o_result  out  BITS  signed result, held until the next accepted start
- o_error  out  1  invalid shift amount, held with o_result
- o_overflow  out  1  left-shift overflow, held with o_result

## Operation
- **States:** IDLE, BUSY, DONE.
  - IDLE→BUSY on i_start=1.
  - BUSY→DONE when the remaining count reaches 0, or immediately for an error request.
  - DONE→IDLE unconditionally after one cycle.
- **Accepting a request:** on i_start in IDLE, capture A, B and mode.
  - Clear o_error and o_overflow.
  - Load the remaining count rem = B.
- **Error:** B < 0 (signed) or B ≥ BITS gives o_error=1, o_result=0 and o_overflow=0.
  - No shifting is performed.
  - The FSM spends exactly one BUSY cycle.
- **BUSY cycle:** s = min(STEP, rem).
  - Shift the working register by s (left fills 0, right fills the sign bit).
  - Set rem -= s.
  - If rem = 0 on entry (B = 0), no shift is performed and the FSM goes to DONE.
- **Overflow (left only):** set sticky when any bit shifted out of position BITS-1 differs from the sign of the original A.
  - Equivalently, set when the final result >>> B ≠ A.
  - Right shifts never set o_overflow.
- **Right shift saturation:** a right shift by BITS-1 yields 0 or -1.
- **Ignored starts:** i_start in BUSY or DONE is ignored and not queued.
- **Input stability:** i_arg_A, i_arg_B and i_mode are don't-care after capture.

## Timing
- **Reset** (asynchronous, any state): FSM=IDLE.
  - o_busy=0, o_done=0, o_result=0, o_error=0, o_overflow=0.
  - Internal count cleared.
  - An operation in flight is discarded, with no o_done pulse.
- **Start accepted** at rising edge T0. o_busy=1 from T0.
- **BUSY cycle count:** k = max(1, ceil(B/STEP)) for valid B; k = 1 for error.
- **Completion:** o_done=1, o_busy=0 and the final o_result/o_error/o_overflow are registered at edge T0+k.
  - o_done drops at T0+k+1.
  - The earliest next start edge is T0+k+2 (i_start must be high while IDLE is sampled).
- **Hold:** outputs hold their last value between operations; o_result is not updated mid-operation.
- **Throughput:** one operation per k+2 cycles.

## Configuration
- **PRZESUNIECIE_SAT_EN defined:** on left-shift overflow, o_result saturates instead of wrapping.
  - Positive A saturates to 2^(BITS-1)-1.
  - Negative A saturates to -2^(BITS-1).
  - o_overflow is still asserted.
- **PRZESUNIECIE_SAT_EN undefined:** o_result is the wrapped two's-complement shift; o_overflow flags it.
- Error, right-shift and timing behaviour are identical in both builds.

## Test plan
All scenarios use BITS=32, STEP=4.
- **Basic left / zero shift:**
  - A=5, B=3, mode=0 → o_result=40, overflow=0, error=0, o_done at T0+1.
  - A=0x1234, B=0 → o_result=0x1234, o_done at T0+1.
- **Right arithmetic:**
  - A=-8, B=2, mode=1 → o_result=-2.
  - A=-1, B=31 → -1.
  - B=13 → o_done exactly at T0+4, with o_busy high for 4 cycles.
- **Overflow:**
  - A=0x40000000, B=1, mode=0 → overflow=1; o_result=0x80000000 (wrap) or 0x7FFFFFFF (SAT_EN).
  - A=-1, B=31, mode=0 → 0x80000000, overflow=0.
- **Error:**
  - B=32 → error=1, result=0, o_done at T0+1.
  - B=34 → error=1, result=0.
  - B=-1 → error=1, result=0.
  - The next valid request clears error.
- **Ignored start:** B=20 in progress with i_start held high in BUSY → a single o_done at T0+5, no second operation until IDLE.
- **Reset mid-operation:** assert i_rst at T0+2 of a B=24 shift → all outputs 0 immediately, no o_done, and a subsequent A=3, B=1 → 6.
